// File: rtl/fpu_unpack_if.sv
// fpu_unpack_if: operand/result valid-ready bundle for the binary32 unpack stage
interface fpu_unpack_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_raw_o;
    logic        out_sign_o;
    logic [9:0]  out_exp_o;
    logic [23:0] out_sig_o;
    logic [5:0]  out_class_o;
    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_raw_o, out_sign_o, out_exp_o, out_sig_o, out_class_o
    );
    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_raw_o, out_sign_o, out_exp_o, out_sig_o, out_class_o
    );
endinterface

// File: rtl/fpu_unpack.sv
// fpu_unpack: binary32 unpack/classify with subnormal normalization; FUNPACK_FAST_NORM_EN selects single-cycle CLZ normalization
module fpu_unpack (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        flush_i,
    fpu_unpack_if.slave bus
);
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
    state_t      state_q, state_d, acc_state;
    logic        in_ready, accept, is_sub;
    logic [7:0]  e;
    logic [22:0] f;
    logic [31:0] raw_q, raw_d;
    logic        sign_q, sign_d;
    logic [9:0]  exp_q, exp_d;
    logic [23:0] sig_q, sig_d;
    logic [5:0]  class_q, class_d;

    assign e      = bus.in_data_i[30:23];
    assign f      = bus.in_data_i[22:0];
    assign is_sub = (e == 8'd0) && (f != 23'd0);
    assign accept = bus.in_valid_i && in_ready && !flush_i;

`ifdef FUNPACK_FAST_NORM_EN
    logic [4:0] lz;
    // Leading-zero count of {0,F}; highest set bit wins, only used for subnormals
    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 23; i++)
            if (f[i]) lz = 5'(23 - i);
    end
    assign acc_state = DONE;
`else
    assign acc_state = is_sub ? NORM : DONE;
`endif

    // State register
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next state: flush wins, then accept, then NORM exit on hidden bit, then output handshake
    always_comb begin
        state_d = state_q;
        if (flush_i)                                  state_d = IDLE;
        else if (accept)                              state_d = acc_state;
        else if (state_q == NORM)                     state_d = sig_q[22] ? DONE : NORM;
        else if (state_q == DONE && bus.out_ready_i)  state_d = IDLE;
    end

    // Handshake outputs decoded from state; out_ready_i -> in_ready_o is the only comb path
    always_comb begin
        in_ready        = (state_q == IDLE) || (state_q == DONE && bus.out_ready_i);
        bus.out_valid_o = (state_q == DONE);
    end

    // Datapath next values: decode on accept, shift-and-decrement while normalizing
    always_comb begin
        raw_d   = raw_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        sig_d   = sig_q;
        class_d = class_q;
        if (accept) begin
            raw_d   = bus.in_data_i;
            sign_d  = bus.in_data_i[31];
            sig_d   = {(e != 8'd0) && (e != 8'hFF), f};
            exp_d   = (e == 8'hFF) ? 10'd128 :
                      (e == 8'd0)  ? (is_sub ? 10'h382 : 10'd0) :
                                     10'(e) - 10'd127;
            class_d = (e == 8'hFF) ? ((f == 23'd0) ? 6'b001000 : f[22] ? 6'b100000 : 6'b010000) :
                      (e != 8'd0)  ? 6'b000100 :
                      is_sub       ? 6'b000010 : 6'b000001;
`ifdef FUNPACK_FAST_NORM_EN
            if (is_sub) begin
                sig_d = {1'b0, f} << lz;
                exp_d = 10'h382 - 10'(lz);
            end
`endif
        end else if (state_q == NORM && !flush_i) begin
            sig_d = sig_q << 1;
            exp_d = exp_q - 10'd1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            raw_q   <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            sig_q   <= '0;
            class_q <= '0;
        end else begin
            raw_q   <= raw_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            sig_q   <= sig_d;
            class_q <= class_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_raw_o   = raw_q;
    assign bus.out_sign_o  = sign_q;
    assign bus.out_exp_o   = exp_q;
    assign bus.out_sig_o   = sig_q;
    assign bus.out_class_o = class_q;
endmodule
